nios_accelerometer_fir_in_x: RTL and testbench

Avalon-MM slave input port that returns filtered accelerometer samples from the hardware FIR pipeline to the Nios CPU. It is the read-side counterpart of the CPU-written `fir_out` output ports. Each `in_valid` strobe pushes one sample into a small FIFO. The CPU pops samples through a data register, polls occupancy and overflow through a status register, and can take an interrupt instead of polling.

---
 rtl/nios_accel_pkg.sv | 10 +
 rtl/nios_accel_sample_fifo.sv | 47 ++++
 rtl/nios_accelerometer_fir_in_x.sv | 67 ++++++
 tb/tb_nios_accelerometer_fir_in_x.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/nios_accel_pkg.sv
// nios_accel_pkg: register map, status bit positions and limits for the accelerometer FIR input port
package nios_accel_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_IRQ_EN = 2'd2;
  localparam int ST_EMPTY = 5;
  localparam int ST_FULL = 6;
  localparam int ST_OVF = 7;
  localparam int DEPTH_MAX = 16;
endpackage

// File: rtl/nios_accel_sample_fifo.sv
// nios_accel_sample_fifo: register-based sample FIFO with separate count and drop-on-full overflow pulse
import nios_accel_pkg::*;
module nios_accel_sample_fifo #(
  parameter int DATA_W = 31,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] head,
  output logic [4:0]        count,
  output logic              full,
  output logic              empty,
  output logic              empty_nxt,
  output logic              ovf_pulse
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [4:0] count_nxt;
  logic push_eff, pop_eff;
  always_comb begin
    empty = count == 5'd0;
    full = count == 5'(DEPTH);
    pop_eff = pop && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    push_eff = push && (!full || pop_eff);
    ovf_pulse = push && !push_eff;
    count_nxt = count + 5'(push_eff) - 5'(pop_eff);
    empty_nxt = count_nxt == 5'd0;
    head = mem[rp];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push_eff);
      rp <= rp + AW'(pop_eff);
      count <= count_nxt;
    end
  always_ff @(posedge clk)
    if (push_eff) mem[wp] <= data_in;
endmodule

// File: rtl/nios_accelerometer_fir_in_x.sv
// nios_accelerometer_fir_in_x: Avalon-MM slave exposing FIR output samples to the Nios CPU via FIFO, status and irq
import nios_accel_pkg::*;
module nios_accelerometer_fir_in_x #(
  parameter int DATA_W = 31,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);
  logic [DATA_W-1:0] head;
  logic [4:0] count;
  logic full, empty, empty_nxt, ovf_pulse;
  logic rd, wr, pop, ovf, ovf_nxt;
  logic [1:0] irq_en, irq_en_nxt;
  logic [31:0] status, data_ext;
  logic unused_bits;
  assign unused_bits = ^{writedata[31:8], writedata[6:2]};
  nios_accel_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(in_valid),
    .pop(pop),
    .data_in(in_data),
    .head(head),
    .count(count),
    .full(full),
    .empty(empty),
    .empty_nxt(empty_nxt),
    .ovf_pulse(ovf_pulse)
  );
  always_comb begin
    rd = chipselect && !read_n;
    wr = chipselect && !write_n;
    pop = rd && address == ADDR_DATA;
    // set beats a simultaneous write-1-to-clear so no dropped sample goes unreported
    ovf_nxt = ovf_pulse ? 1'b1 : (wr && address == ADDR_STATUS && writedata[ST_OVF]) ? 1'b0 : ovf;
    irq_en_nxt = (wr && address == ADDR_IRQ_EN) ? writedata[1:0] : irq_en;
    status = 32'd0;
    status[4:0] = count;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_OVF] = ovf;
    data_ext = {{(32-DATA_W){head[DATA_W-1]}}, head};
    readdata = address == ADDR_DATA ? (empty ? 32'd0 : data_ext) :
               address == ADDR_STATUS ? status :
               address == ADDR_IRQ_EN ? {30'd0, irq_en} : 32'd0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ovf <= 1'b0;
      irq_en <= 2'b0;
      irq <= 1'b0;
    end else begin
      ovf <= ovf_nxt;
      irq_en <= irq_en_nxt;
      irq <= (irq_en_nxt[0] && !empty_nxt) || (irq_en_nxt[1] && ovf_nxt);
    end
endmodule

// File: tb/tb_nios_accelerometer_fir_in_x.sv
// tb_nios_accelerometer_fir_in_x: directed self-checking bench for the FIR input port
module tb_nios_accelerometer_fir_in_x;
  logic clk = 0;
  logic reset_n = 0;
  logic [30:0] in_data = '0;
  logic in_valid = 0;
  logic [1:0] address = '0;
  logic chipselect = 0;
  logic read_n = 1;
  logic write_n = 1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic irq;
  int nvec = 0;
  int nerr = 0;

  nios_accelerometer_fir_in_x #(.DATA_W(31), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .address(address), .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [30:0] v);
    @(negedge clk);
    in_data = v;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    chipselect = 1;
    read_n = 0;
    #1 d = readdata;
    @(negedge clk);
    chipselect = 0;
    read_n = 1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    writedata = d;
    chipselect = 1;
    write_n = 0;
    @(negedge clk);
    chipselect = 0;
    write_n = 1;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rd(2'd1, d);
    nvec++; if (d !== 32'h20) begin nerr++; $display("FAIL reset_status got %h want %h", d, 32'h20); end
    rd(2'd0, d);
    nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL reset_data got %h want %h", d, 32'h0); end
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL reset_irq got %b want 0", irq); end
  endtask

  task automatic test_push_pop;
    logic [31:0] d;
    logic [31:0] exp [3] = '{32'h00000003, 32'hFFFFFFFF, 32'h3FFFFFFF};
    push(31'd3);
    push(31'h7FFFFFFF);
    push(31'h3FFFFFFF);
    rd(2'd1, d);
    nvec++; if (d !== 32'h03) begin nerr++; $display("FAIL pp_status got %h want %h", d, 32'h03); end
    for (int i = 0; i < 3; i++) begin
      rd(2'd0, d);
      nvec++; if (d !== exp[i]) begin nerr++; $display("FAIL pp_data%0d got %h want %h", i, d, exp[i]); end
    end
    rd(2'd1, d);
    nvec++; if (d !== 32'h20) begin nerr++; $display("FAIL pp_status_end got %h want %h", d, 32'h20); end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    for (int i = 0; i < 5; i++) push(31'(10 + i));
    rd(2'd1, d);
    nvec++; if (d !== 32'hC4) begin nerr++; $display("FAIL ovf_status got %h want %h", d, 32'hC4); end
    @(negedge clk);
    in_data = 31'd77;
    in_valid = 1;
    address = 2'd1;
    writedata = 32'h80;
    chipselect = 1;
    write_n = 0;
    @(negedge clk);
    in_valid = 0;
    chipselect = 0;
    write_n = 1;
    rd(2'd1, d);
    nvec++; if (d !== 32'hC4) begin nerr++; $display("FAIL ovf_set_wins got %h want %h", d, 32'hC4); end
    wr(2'd1, 32'h80);
    rd(2'd1, d);
    nvec++; if (d !== 32'h44) begin nerr++; $display("FAIL ovf_clear got %h want %h", d, 32'h44); end
    for (int i = 0; i < 4; i++) begin
      rd(2'd0, d);
      nvec++; if (d !== 32'(10 + i)) begin nerr++; $display("FAIL ovf_data%0d got %h want %h", i, d, 32'(10 + i)); end
    end
    rd(2'd1, d);
    nvec++; if (d !== 32'h20) begin nerr++; $display("FAIL ovf_end got %h want %h", d, 32'h20); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) push(31'(20 + i));
    @(negedge clk);
    in_data = 31'd24;
    in_valid = 1;
    address = 2'd0;
    chipselect = 1;
    read_n = 0;
    #1 d = readdata;
    @(negedge clk);
    in_valid = 0;
    chipselect = 0;
    read_n = 1;
    nvec++; if (d !== 32'd20) begin nerr++; $display("FAIL b2b_pop got %h want %h", d, 32'd20); end
    rd(2'd1, d);
    nvec++; if (d !== 32'h44) begin nerr++; $display("FAIL b2b_status got %h want %h", d, 32'h44); end
    for (int i = 0; i < 4; i++) begin
      rd(2'd0, d);
      nvec++; if (d !== 32'(21 + i)) begin nerr++; $display("FAIL b2b_data%0d got %h want %h", i, d, 32'(21 + i)); end
    end
    @(negedge clk);
    in_data = 31'd99;
    in_valid = 1;
    address = 2'd0;
    chipselect = 1;
    read_n = 0;
    #1 d = readdata;
    @(negedge clk);
    in_valid = 0;
    chipselect = 0;
    read_n = 1;
    nvec++; if (d !== 32'd0) begin nerr++; $display("FAIL empty_pp_data got %h want 0", d); end
    rd(2'd1, d);
    nvec++; if (d !== 32'h01) begin nerr++; $display("FAIL empty_pp_status got %h want %h", d, 32'h01); end
    rd(2'd0, d);
    nvec++; if (d !== 32'd99) begin nerr++; $display("FAIL empty_pp_pushed got %h want %h", d, 32'd99); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    wr(2'd2, 32'hFFFF_FFFD);
    rd(2'd2, d);
    nvec++; if (d !== 32'h1) begin nerr++; $display("FAIL irq_en_read got %h want %h", d, 32'h1); end
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL irq_idle got %b want 0", irq); end
    push(31'd5);
    nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL irq_push got %b want 1", irq); end
    @(negedge clk);
    address = 2'd0;
    chipselect = 1;
    read_n = 0;
    #1 nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL irq_before_pop got %b want 1", irq); end
    @(negedge clk);
    chipselect = 0;
    read_n = 1;
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL irq_after_pop got %b want 0", irq); end
    wr(2'd2, 32'h2);
    push(31'd1);
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL irq_ovf_en_noovf got %b want 0", irq); end
    for (int i = 0; i < 4; i++) push(31'd1);
    nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL irq_ovf got %b want 1", irq); end
    @(negedge clk);
    nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL irq_ovf_hold got %b want 1", irq); end
    wr(2'd1, 32'h80);
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL irq_ovf_clear got %b want 0", irq); end
    for (int i = 0; i < 4; i++) rd(2'd0, d);
    wr(2'd2, 32'h0);
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    wr(2'd2, 32'h3);
    push(31'd7);
    push(31'd8);
    nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL ar_irq_before got %b want 1", irq); end
    address = 2'd1;
    #2 reset_n = 0;
    #1 nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL ar_irq_immediate got %b want 0", irq); end
    nvec++; if (readdata !== 32'h20) begin nerr++; $display("FAIL ar_status_in_reset got %h want %h", readdata, 32'h20); end
    @(negedge clk);
    reset_n = 1;
    rd(2'd1, d);
    nvec++; if (d !== 32'h20) begin nerr++; $display("FAIL ar_status got %h want %h", d, 32'h20); end
    rd(2'd2, d);
    nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL ar_irq_en got %h want 0", d); end
    rd(2'd0, d);
    nvec++; if (d !== 32'h0) begin nerr++; $display("FAIL ar_data got %h want 0", d); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1;
    test_reset();
    test_push_pop();
    test_overflow();
    test_back_to_back();
    test_irq();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
